// File: rtl/noise_gen_pkg.sv
// noise_gen_pkg: shared types, constants and helpers for the noise_gen stimulus source.
//   DW         sample width (fixed 8, matches the FIR input width)
//   LFSR_MASK  Galois feedback mask applied when the shifted-out bit is 1
//   state_e    generator FSM states
//   LUT_DEPTH  entries in the quarter-wave sine ROM
//   TONE_AMP   peak tone amplitude
//   sat8()     clamp a 9-bit signed sum to the 8-bit signed range
package noise_gen_pkg;

  localparam int unsigned DW        = 8;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int unsigned LUT_DEPTH = 64;
  localparam int unsigned TONE_AMP  = 63;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Overflow shows as disagreement between the two top bits of the 9-bit sum.
  function automatic logic signed [DW-1:0] sat8(input logic signed [DW:0] x);
    if (x[DW] == x[DW-1]) begin
      return x[DW-1:0];
    end else if (x[DW]) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/noise_gen_sine_lut.sv
// sine_lut_q: combinational quarter-wave sine ROM, 8-bit phase in, signed tone out.
//   i_phase  [7:0]  phase; [7:6] selects the quadrant, [5:0] indexes the ROM
//   o_tone   [7:0]  signed tone sample in [-TONE_AMP, +TONE_AMP]
// ROM holds round(TONE_AMP * sin(pi/2 * i / LUT_DEPTH)) for i in 0..LUT_DEPTH-1.
module sine_lut_q
  import noise_gen_pkg::*;
(
  input  logic        [7:0]    i_phase,
  output logic signed [DW-1:0] o_tone
);

  localparam logic [7:0] Lut [LUT_DEPTH] = '{
    8'd0,  8'd2,  8'd3,  8'd5,  8'd6,  8'd8,  8'd9,  8'd11,
    8'd12, 8'd14, 8'd15, 8'd17, 8'd18, 8'd20, 8'd21, 8'd23,
    8'd24, 8'd26, 8'd27, 8'd28, 8'd30, 8'd31, 8'd32, 8'd34,
    8'd35, 8'd36, 8'd38, 8'd39, 8'd40, 8'd41, 8'd42, 8'd43,
    8'd45, 8'd46, 8'd47, 8'd48, 8'd49, 8'd50, 8'd51, 8'd52,
    8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd56, 8'd57, 8'd58,
    8'd58, 8'd59, 8'd59, 8'd60, 8'd60, 8'd61, 8'd61, 8'd61,
    8'd62, 8'd62, 8'd62, 8'd63, 8'd63, 8'd63, 8'd63, 8'(TONE_AMP)
  };

  logic [5:0] w_idx;
  logic [7:0] w_mag;

  // Odd quadrants read the ROM mirrored; the upper half-cycle is negated.
  assign w_idx  = i_phase[6] ? ~i_phase[5:0] : i_phase[5:0];
  assign w_mag  = Lut[w_idx];
  assign o_tone = i_phase[7] ? (8'd0 - w_mag) : w_mag;

endmodule

// File: rtl/noise_gen.sv
// noise_gen: paced signed 8-bit stimulus stream for the FIR datapath.
// 16-bit Galois LFSR noise, optionally summed with a sine tone, saturated to 8 bits.
// Ports:
//   clk      clock, all logic on posedge
//   rst      synchronous active-high reset
//   en_i     run enable; low pauses generation without losing state
//   data_o   registered signed sample
//   valid_o  one-cycle strobe, data_o holds a new sample
//   done_o   sticky, NUM_SAMPLES samples have been emitted
// Build option: define NOISE_GEN_TONE_EN to add the sine tone (phase register + ROM).
module noise_gen
  import noise_gen_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 10000,
  parameter int unsigned RATE_DIV    = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned NOISE_SHIFT = 0,
  parameter logic [7:0]  PHASE_INC   = 8'd13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  output logic signed [DW-1:0] data_o,
  output logic                 valid_o,
  output logic                 done_o
);

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [31:0] DivLast = RATE_DIV - 1;
  localparam logic [31:0] SmpLast = NUM_SAMPLES - 1;

  state_e                r_state, w_state_next;
  logic           [15:0] r_lfsr;
  logic           [31:0] r_div_cnt;
  logic           [31:0] r_smp_cnt;
  logic signed [DW-1:0]  r_data;
  logic                  r_valid;
  logic                  r_done;

  logic                  w_strobe;
  logic           [15:0] w_lfsr_next;
  logic signed [DW-1:0]  w_noise;
  logic signed [DW-1:0]  w_tone;
  logic signed [DW:0]    w_sum;

  assign w_strobe    = (r_state == RUN) && en_i && (r_div_cnt == DivLast);
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
  assign w_noise     = $signed(w_lfsr_next[DW-1:0]) >>> NOISE_SHIFT;
  assign w_sum       = {w_noise[DW-1], w_noise} + {w_tone[DW-1], w_tone};

`ifdef NOISE_GEN_TONE_EN
  logic [7:0] r_phase;

  // Sample k uses phase k*PHASE_INC: the phase advances only after it has been used.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 8'd0;
    end else if (w_strobe) begin
      r_phase <= r_phase + PHASE_INC;
    end
  end

  sine_lut_q u_sine_lut (
    .i_phase (r_phase),
    .o_tone  (w_tone)
  );
`else
  logic w_unused_phase_inc;

  assign w_tone             = '0;
  assign w_unused_phase_inc = ^PHASE_INC;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (en_i) begin
          w_state_next = (NUM_SAMPLES == 0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_strobe && (r_smp_cnt == SmpLast)) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lfsr    <= SeedEff;
      r_div_cnt <= '0;
      r_smp_cnt <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_strobe;
      // DONE is entered on the last strobe, so this lands one cycle after the last valid.
      r_done  <= (r_state == DONE);
      if ((r_state == RUN) && en_i) begin
        r_div_cnt <= (r_div_cnt == DivLast) ? 32'd0 : r_div_cnt + 32'd1;
      end
      if (w_strobe) begin
        r_lfsr    <= w_lfsr_next;
        r_smp_cnt <= r_smp_cnt + 32'd1;
        r_data    <= sat8(w_sum);
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign done_o  = r_done;

endmodule

// File: tb/tb_noise_gen.sv
// tb_noise_gen: scoreboard bench for noise_gen.
// u_dut_a: RATE_DIV=1, seed ACE1, 10000 samples. u_dut_b: RATE_DIV=4, 5 samples, seed 0, shift 2.
// Expected samples come from an independent LFSR/sine model and are queued per DUT;
// negedge monitors pop and compare whenever valid_o is high.
module tb_noise_gen;

  localparam int NumA = 10000;
`ifdef NOISE_GEN_TONE_EN
  localparam bit ToneEn = 1'b1;
`else
  localparam bit ToneEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic signed [7:0] data_a, data_b;
  logic valid_a, valid_b, done_a, done_b;

  int checks = 0;
  int failures = 0;
  int q_a[$];
  int q_b[$];
  int e_a, e_b;
  int rail_a = 0;
  logic [15:0] ma_lfsr, mb_lfsr;
  int ma_ph, mb_ph;

  always #5 clk = ~clk;

  noise_gen #(
    .NUM_SAMPLES (NumA),
    .RATE_DIV    (1),
    .LFSR_SEED   (16'hACE1),
    .NOISE_SHIFT (0),
    .PHASE_INC   (8'd64)
  ) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_a),
    .data_o  (data_a),
    .valid_o (valid_a),
    .done_o  (done_a)
  );

  noise_gen #(
    .NUM_SAMPLES (5),
    .RATE_DIV    (4),
    .LFSR_SEED   (16'h0000),
    .NOISE_SHIFT (2),
    .PHASE_INC   (8'd13)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_b),
    .data_o  (data_b),
    .valid_o (valid_b),
    .done_o  (done_b)
  );

  // ---------------- reference model ----------------
  function automatic int lut_q(input int i);
    return $rtoi(63.0 * $sin(3.14159265358979 * real'(i) / 128.0) + 0.5);
  endfunction

  function automatic int tone_of(input int ph);
    int idx;
    int mag;
    idx = ph % 64;
    mag = (((ph / 64) % 2) == 1) ? lut_q(63 - idx) : lut_q(idx);
    return (ph >= 128) ? -mag : mag;
  endfunction

  task automatic model_next(inout logic [15:0] s, inout int ph, input int shift, input int inc,
                            output int smp);
    int n;
    int t;
    s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    n = int'($signed(s[7:0])) >>> shift;
    t = ToneEn ? tone_of(ph) : 0;
    smp = n + t;
    if (smp > 127) smp = 127;
    if (smp < -128) smp = -128;
    if (ToneEn) ph = (ph + inc) % 256;
  endtask

  task automatic push_a(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      model_next(ma_lfsr, ma_ph, 0, 64, s);
      q_a.push_back(s);
    end
  endtask

  // Enables A until n samples were seen, then stops it at once (en low, or rst high).
  task automatic run_a(input int n, input int budget, input bit stop_rst, output int got);
    got = 0;
    en_a = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (valid_a === 1'b1) got++;
    end
    if (stop_rst) rst = 1'b1;
    else en_a = 1'b0;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL a_extra_sample: got data_o=%0d, required no valid_o", data_a);
      end else begin
        e_a = q_a.pop_front();
        if (int'(data_a) !== e_a) begin
          failures++;
          $display("FAIL a_sample: got %0d, required %0d", data_a, e_a);
        end
      end
      if (data_a == 8'sd127 || data_a == -8'sd128) rail_a++;
    end
  end

  always @(negedge clk) begin
    if (valid_b === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL b_extra_sample: got data_o=%0d, required no valid_o", data_b);
      end else begin
        e_b = q_b.pop_front();
        if (int'(data_b) !== e_b) begin
          failures++;
          $display("FAIL b_sample: got %0d, required %0d", data_b, e_b);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({data_a, valid_a, done_a} !== 10'b0) begin
        failures++;
        $display("FAIL reset_a: got data=%0d valid=%b done=%b, required 0 0 0",
                 data_a, valid_a, done_a);
      end
      checks++;
      if ({data_b, valid_b, done_b} !== 10'b0) begin
        failures++;
        $display("FAIL reset_b: got data=%0d valid=%b done=%b, required 0 0 0",
                 data_b, valid_b, done_b);
      end
    end
    en_b = 1'b0;
  endtask

  task automatic test_noise();
    int lit[4];
    int dummy;
    int got;
    if (ToneEn) lit = '{112, 119, -100, 15};
    else lit = '{112, 56, -100, 78};
    ma_lfsr = 16'hACE1;
    ma_ph = 0;
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(lit[i]);
      model_next(ma_lfsr, ma_ph, 0, 64, dummy);
    end
    rst = 1'b0;
    run_a(4, 20, 1'b0, got);
    @(negedge clk);
    checks++;
    if (got !== 4 || q_a.size() != 0) begin
      failures++;
      $display("FAIL first_samples: got %0d samples (%0d pending), required 4", got, q_a.size());
    end
  endtask

  task automatic test_pause();
    int got;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b0) begin
        failures++;
        $display("FAIL pause_valid: got valid_o=%b, required 0", valid_a);
      end
    end
    push_a(4);
    run_a(4, 20, 1'b0, got);
    @(negedge clk);
    checks++;
    if (got !== 4 || q_a.size() != 0) begin
      failures++;
      $display("FAIL resume: got %0d samples (%0d pending), required 4", got, q_a.size());
    end
    // Reset while running: the stream restarts from the seed.
    push_a(3);
    run_a(3, 20, 1'b1, got);
    repeat (2) @(negedge clk);
    ma_lfsr = 16'hACE1;
    ma_ph = 0;
    q_a.push_back(112);
    model_next(ma_lfsr, ma_ph, 0, 64, got);
    rst = 1'b0;
    run_a(1, 20, 1'b0, got);
    @(negedge clk);
    checks++;
    if (got !== 1 || q_a.size() != 0) begin
      failures++;
      $display("FAIL reset_restart: got %0d samples (%0d pending), required 1", got, q_a.size());
    end
  endtask

  task automatic test_rate_div();
    int s;
    int pulses = 0;
    int last = 0;
    int last5 = 0;
    bit exp_done;
    mb_lfsr = 16'h0001;  // zero seed is replaced by 1
    mb_ph = 0;
    for (int i = 0; i < 5; i++) begin
      model_next(mb_lfsr, mb_ph, 2, 13, s);
      q_b.push_back(s);
    end
    en_b = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (valid_b === 1'b1) begin
        pulses++;
        if (pulses > 1) begin
          checks++;
          if (cyc - last !== 4) begin
            failures++;
            $display("FAIL rate_gap: got %0d cycles between pulses, required 4", cyc - last);
          end
        end
        last = cyc;
        if (pulses == 5) last5 = cyc;
      end
      exp_done = (pulses >= 5) && (cyc > last5);
      checks++;
      if (done_b !== exp_done) begin
        failures++;
        $display("FAIL done_timing: cycle %0d got done_o=%b, required %b", cyc, done_b, exp_done);
      end
    end
    checks++;
    if (pulses !== 5 || q_b.size() != 0) begin
      failures++;
      $display("FAIL pulse_count: got %0d pulses (%0d pending), required 5", pulses, q_b.size());
    end
    en_b = 1'b0;
  endtask

  task automatic test_long();
    int got = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ma_lfsr = 16'hACE1;
    ma_ph = 0;
    rail_a = 0;
    push_a(NumA);
    rst = 1'b0;
    en_a = 1'b1;
    for (int c = 0; c < NumA + 200; c++) begin
      @(negedge clk);
      if (valid_a === 1'b1) got++;
      if (done_a === 1'b1) break;
    end
    checks++;
    if (got !== NumA || done_a !== 1'b1) begin
      failures++;
      $display("FAIL long_run: got %0d samples done_o=%b, required %0d and 1", got, done_a, NumA);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b0 || done_a !== 1'b1) begin
        failures++;
        $display("FAIL after_done: got valid_o=%b done_o=%b, required 0 1", valid_a, done_a);
      end
    end
    checks++;
    if (q_a.size() != 0) begin
      failures++;
      $display("FAIL long_pending: got %0d unmatched samples, required 0", q_a.size());
    end
`ifdef NOISE_GEN_TONE_EN
    checks++;
    if (rail_a == 0) begin
      failures++;
      $display("FAIL saturation: got %0d rail samples, required > 0", rail_a);
    end
`endif
    en_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_noise();
    test_pause();
    test_rate_div();
    test_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
